// File: rtl/step_sequencer.sv
// Step counter and instruction latch for the multicycle RISC controller.
// Fetches at Cnt==0, decodes to InsID, and ends each instruction on Buff_PC.
module step_sequencer #(
    parameter logic [2:0] MAX_CNT = 3'd7
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [15:0] Ins,
    input  logic        Buff_PC,
    output logic [2:0]  Cnt,
    output logic [4:0]  InsM,
    output logic [2:0]  InsC,
    output logic [1:0]  InsL,
    output logic [5:0]  InsID,
    output logic        Illegal,
    output logic        Halted,
    output logic        Overrun
);

    localparam logic [5:0] HLT_ID = 6'h19;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt_next;
    logic        overrun_next;
    logic        fetch;
    logic [5:0]  decoded_id;

    // Ins[7:2] carries no opcode information; folding it here keeps lint quiet.
    logic unused_ins;
    assign unused_ins = ^Ins[7:2];

    assign Halted = (state == HALT);

    // Decode straight from the bus so InsID lands at the same edge as the field latch.
    always_comb begin
        decoded_id = 6'h00;
        case (Ins[15:11])
            5'b00001: decoded_id = 6'h01;
            5'b00010: decoded_id = 6'h02;
            5'b00011: decoded_id = 6'h03;
            5'b00100: if (Ins[1:0] == 2'b00) decoded_id = 6'h04;
            5'b00101: decoded_id = 6'h05;
            5'b00110: begin
                if (Ins[1:0] == 2'b00)      decoded_id = 6'h06;
                else if (Ins[1:0] == 2'b01) decoded_id = 6'h0B;
            end
            5'b00000: decoded_id = 6'h07 + {4'b0000, Ins[1:0]};
            5'b00111: decoded_id = 6'h0C;
            5'b01000: decoded_id = 6'h0D;
            5'b01011: decoded_id = 6'h0E;
            5'b11000: begin
                case (Ins[10:8])
                    3'b011:  decoded_id = 6'h0F;
                    3'b010:  decoded_id = 6'h10;
                    3'b001:  decoded_id = 6'h11;
                    3'b000:  decoded_id = 6'h12;
                    default: decoded_id = 6'h00;
                endcase
            end
            5'b11001: if (Ins[10:8] == 3'b110) decoded_id = 6'h13;
            5'b10000: decoded_id = 6'h14;
            5'b10001: decoded_id = 6'h15;
            5'b10010: decoded_id = 6'h16;
            5'b10011: decoded_id = 6'h17;
            5'b11100: begin
                if (Ins[1:0] == 2'b00)      decoded_id = 6'h18;
                else if (Ins[1:0] == 2'b01) decoded_id = 6'h19;
            end
            default: decoded_id = 6'h00;
        endcase
    end

    // Buff_PC outranks the overrun check, so a step-7 end is not an error.
    always_comb begin
        state_next   = state;
        cnt_next     = Cnt;
        overrun_next = Overrun;
        fetch        = 1'b0;
        case (state)
            RUN: begin
                fetch = (Cnt == 3'd0);
                if (Buff_PC) begin
                    cnt_next = 3'd0;
                    if (InsID == HLT_ID)
                        state_next = HALT;
                end else if (Cnt == MAX_CNT) begin
                    cnt_next     = 3'd0;
                    overrun_next = 1'b1;
                end else begin
                    cnt_next = Cnt + 3'd1;
                end
            end
            HALT: begin
                cnt_next = 3'd0;
            end
            default: begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            Cnt     <= 3'd0;
            InsM    <= 5'd0;
            InsC    <= 3'd0;
            InsL    <= 2'd0;
            InsID   <= 6'd0;
            Illegal <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            Cnt     <= cnt_next;
            Overrun <= overrun_next;
            if (fetch) begin
                InsM    <= Ins[15:11];
                InsC    <= Ins[10:8];
                InsL    <= Ins[1:0];
                InsID   <= decoded_id;
                Illegal <= (decoded_id == 6'h00);
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: reset, fetch/decode, overrun, halt.
module tb_step_sequencer;

    logic        clk;
    logic        Rst;
    logic [15:0] Ins;
    logic        Buff_PC;
    logic [2:0]  Cnt;
    logic [4:0]  InsM;
    logic [2:0]  InsC;
    logic [1:0]  InsL;
    logic [5:0]  InsID;
    logic        Illegal;
    logic        Halted;
    logic        Overrun;

    int errors;
    int checks;

    step_sequencer dut (
        .clk     (clk),
        .Rst     (Rst),
        .Ins     (Ins),
        .Buff_PC (Buff_PC),
        .Cnt     (Cnt),
        .InsM    (InsM),
        .InsC    (InsC),
        .InsL    (InsL),
        .InsID   (InsID),
        .Illegal (Illegal),
        .Halted  (Halted),
        .Overrun (Overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        Buff_PC = 1'b0;
        tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Buff_PC = 1'b0;
        Ins = 16'hFFFF;
        tick();
        tick();
        checks++;
        if ({Cnt, InsM, InsC, InsL, InsID, Illegal, Halted, Overrun} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got Cnt=%0d InsM=%0h InsC=%0h InsL=%0h InsID=%0h Ill=%0b Halt=%0b Ovr=%0b, want all 0",
                     Cnt, InsM, InsC, InsL, InsID, Illegal, Halted, Overrun);
        end
        Rst = 1'b0;
        Ins = 16'h0000;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (Cnt !== 3'(i)) begin
                errors++;
                $display("[TB] FAIL reset_count_step%0d: got Cnt=%0d, want %0d", i, Cnt, i);
            end
        end
    endtask

    task automatic test_adc_fetch();
        do_reset();
        Ins = 16'h0001;
        tick();
        Ins = 16'hFFFF;
        checks++;
        if (Cnt !== 3'd1 || InsM !== 5'b00000 || InsL !== 2'b01 || InsID !== 6'h08 || Illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL adc_fetch: got Cnt=%0d InsM=%b InsL=%b InsID=%0h Ill=%0b, want 1 00000 01 08 0",
                     Cnt, InsM, InsL, InsID, Illegal);
        end
        tick();
        checks++;
        if (Cnt !== 3'd2 || InsID !== 6'h08 || InsM !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL adc_hold: got Cnt=%0d InsM=%b InsID=%0h, want 2 00000 08", Cnt, InsM, InsID);
        end
        tick();
        Buff_PC = 1'b1;
        tick();
        Buff_PC = 1'b0;
        checks++;
        if (Cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL adc_end: got Cnt=%0d, want 0", Cnt);
        end
    endtask

    task automatic test_decode_all();
        logic [15:0] enc [25];
        enc = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2800, 16'h3000,
                16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h3001, 16'h3800,
                16'h4000, 16'h5800, 16'hC300, 16'hC200, 16'hC100, 16'hC000,
                16'hCE00, 16'h8000, 16'h8800, 16'h9000, 16'h9800, 16'hE000,
                16'hE001};
        do_reset();
        for (int i = 0; i < 25; i++) begin
            Ins = enc[i];
            tick();
            checks++;
            if (InsID !== 6'(i + 1) || Illegal !== 1'b0 || Cnt !== 3'd1) begin
                errors++;
                $display("[TB] FAIL decode_%0h: Ins=%h got InsID=%0h Ill=%0b Cnt=%0d, want %0h 0 1",
                         i + 1, enc[i], InsID, Illegal, Cnt, i + 1);
            end
            tick();
            tick();
            Buff_PC = 1'b1;
            tick();
            Buff_PC = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_illegal();
        do_reset();
        Ins = 16'hC300;
        tick();
        checks++;
        if (InsID !== 6'h0F || Illegal !== 1'b0 || InsC !== 3'b011) begin
            errors++;
            $display("[TB] FAIL bcc_decode: got InsID=%0h Ill=%0b InsC=%b, want 0f 0 011", InsID, Illegal, InsC);
        end
        Buff_PC = 1'b1;
        tick();
        Ins = 16'hC600;
        Buff_PC = 1'b0;
        tick();
        checks++;
        if (InsID !== 6'h00 || Illegal !== 1'b1 || InsC !== 3'b110) begin
            errors++;
            $display("[TB] FAIL illegal_decode: got InsID=%0h Ill=%0b InsC=%b, want 00 1 110", InsID, Illegal, InsC);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        Ins = 16'h0800;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (Cnt !== 3'd7 || Overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_pre: got Cnt=%0d Ovr=%0b, want 7 0", Cnt, Overrun);
        end
        tick();
        checks++;
        if (Cnt !== 3'd0 || Overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set: got Cnt=%0d Ovr=%0b, want 0 1", Cnt, Overrun);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (Cnt !== 3'd4 || Overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: got Cnt=%0d Ovr=%0b, want 4 1", Cnt, Overrun);
        end
        Rst = 1'b1;
        Buff_PC = 1'b1;
        tick();
        Rst = 1'b0;
        Buff_PC = 1'b0;
        checks++;
        if (Overrun !== 1'b0 || Cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got Ovr=%0b Cnt=%0d, want 0 0", Overrun, Cnt);
        end
        for (int i = 0; i < 7; i++) tick();
        Buff_PC = 1'b1;
        tick();
        Buff_PC = 1'b0;
        checks++;
        if (Cnt !== 3'd0 || Overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bpc_at_max: got Cnt=%0d Ovr=%0b, want 0 0", Cnt, Overrun);
        end
    endtask

    task automatic test_bpc_at_fetch();
        do_reset();
        Ins = 16'h1000;
        Buff_PC = 1'b1;
        tick();
        Buff_PC = 1'b0;
        checks++;
        if (Cnt !== 3'd0 || InsID !== 6'h02 || InsM !== 5'b00010) begin
            errors++;
            $display("[TB] FAIL bpc_fetch: got Cnt=%0d InsID=%0h InsM=%b, want 0 02 00010", Cnt, InsID, InsM);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        Ins = 16'h2800;
        tick();
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checks++;
        if (Cnt !== 3'd0 || InsID !== 6'h00 || InsM !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got Cnt=%0d InsID=%0h InsM=%b, want 0 00 00000", Cnt, InsID, InsM);
        end
        Ins = 16'h8800;
        tick();
        checks++;
        if (Cnt !== 3'd1 || InsID !== 6'h15) begin
            errors++;
            $display("[TB] FAIL reset_mid_fetch: got Cnt=%0d InsID=%0h, want 1 15", Cnt, InsID);
        end
    endtask

    task automatic test_halt();
        do_reset();
        Ins = 16'hE001;
        tick();
        Ins = 16'h0800;
        tick();
        Buff_PC = 1'b1;
        tick();
        Buff_PC = 1'b0;
        checks++;
        if (Halted !== 1'b1 || Cnt !== 3'd0) begin
            errors++;
            $display("[TB] FAIL halt_enter: got Halt=%0b Cnt=%0d, want 1 0", Halted, Cnt);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (Halted !== 1'b1 || Cnt !== 3'd0 || InsM !== 5'b11100 || InsID !== 6'h19 || Overrun !== 1'b0) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d: got Halt=%0b Cnt=%0d InsM=%b InsID=%0h Ovr=%0b, want 1 0 11100 19 0",
                         i, Halted, Cnt, InsM, InsID, Overrun);
            end
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checks++;
        if (Halted !== 1'b0 || Cnt !== 3'd0 || InsM !== 5'd0) begin
            errors++;
            $display("[TB] FAIL halt_exit: got Halt=%0b Cnt=%0d InsM=%b, want 0 0 00000", Halted, Cnt, InsM);
        end
        tick();
        checks++;
        if (Cnt !== 3'd1 || InsID !== 6'h01) begin
            errors++;
            $display("[TB] FAIL halt_resume: got Cnt=%0d InsID=%0h, want 1 01", Cnt, InsID);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        Rst = 1'b1;
        Ins = 16'h0000;
        Buff_PC = 1'b0;
        test_reset();
        test_adc_fetch();
        test_decode_all();
        test_illegal();
        test_overrun();
        test_bpc_at_fetch();
        test_reset_mid();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
